// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared widths and helpers for the byte-lane data RAM.
// Optional build macro: DATA_RAM_WRITE_FIRST_EN (same-port write-first reads).
package data_ram_pkg;

    localparam int WORD_W         = 32;
    localparam int LANES          = 4;
    localparam int LANE_W         = 8;
    localparam int ADDR_W_DEFAULT = 12;
    localparam int ADDR_PORT_W    = 30;

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [LANES-1:0]       lane_en_t;
    typedef logic [ADDR_PORT_W-1:0] word_addr_t;
    typedef logic [LANE_W-1:0]      lane_t;

    // Extract byte lane idx from a word (lane 0 is the least significant byte).
    function automatic lane_t lane_of(input word_t word, input int idx);
        return word[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// data_ram_if: the two byte-enabled word ports of the data RAM.
// Port A is the main load/store port, port B is the debug port.
// Optional build macro: DATA_RAM_WRITE_FIRST_EN (affects the RAM, not this bundle).
interface data_ram_if;
    import data_ram_pkg::*;

    lane_en_t   wea;
    word_addr_t addra;
    word_t      dina;
    word_t      douta;

    lane_en_t   web;
    word_addr_t addrb;
    word_t      dinb;
    word_t      doutb;

    modport master (
        output wea, addra, dina,
        output web, addrb, dinb,
        input  douta, doutb
    );

    modport slave (
        input  wea, addra, dina,
        input  web, addrb, dinb,
        output douta, doutb
    );

endinterface

// File: rtl/data_ram_lane.sv
// data_ram_lane: one 8-bit slice of the true dual-port RAM.
// Owns the storage array, the port B write priority, reset write gating and
// the two registered read outputs.
// Optional build macro: DATA_RAM_WRITE_FIRST_EN selects write-first same-port
// reads; otherwise the lane is read-first.
module data_ram_lane
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  lane_t             din_a,
    output lane_t             dout_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  lane_t             din_b,
    output lane_t             dout_b
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage carries no reset so it maps onto block RAM; it starts cleared.
    lane_t mem [0:DEPTH-1] = '{default: '0};

    // Array writes: gated off during reset; port B is applied last so it wins
    // when both ports hit the same word on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we_a) begin
                mem[addr_a] <= din_a;
            end
            if (we_b) begin
                mem[addr_b] <= din_b;
            end
        end
    end

    // Port A read register: cleared asynchronously by reset, otherwise loads
    // the addressed lane every cycle (old contents, or own write if write-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a <= '0;
        end else begin
`ifdef DATA_RAM_WRITE_FIRST_EN
            dout_a <= we_a ? din_a : mem[addr_a];
`else
            dout_a <= mem[addr_a];
`endif
        end
    end

    // Port B read register: same behaviour as port A, driven by port B signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_b <= '0;
        end else begin
`ifdef DATA_RAM_WRITE_FIRST_EN
            dout_b <= we_b ? din_b : mem[addr_b];
`else
            dout_b <= mem[addr_b];
`endif
        end
    end

endmodule

// File: rtl/data_ram.sv
// data_ram: 2^ADDR_W x 32-bit true dual-port data memory built from four
// independent byte lanes. Only the low ADDR_W word-address bits are decoded,
// so addresses wrap modulo the depth.
// Optional build macro: DATA_RAM_WRITE_FIRST_EN (write-first same-port reads;
// default build is read-first).
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    data_ram_if.slave bus
);

    logic [ADDR_W-1:0]             idx_a;
    logic [ADDR_W-1:0]             idx_b;
    logic [LANES-1:0][LANE_W-1:0]  rd_a;
    logic [LANES-1:0][LANE_W-1:0]  rd_b;

    assign idx_a     = bus.addra[ADDR_W-1:0];
    assign idx_b     = bus.addrb[ADDR_W-1:0];
    assign bus.douta = rd_a;
    assign bus.doutb = rd_b;

    // Upper word-address bits are deliberately ignored.
    if (ADDR_W < ADDR_PORT_W) begin : g_unused_addr
        logic unused_addr_bits;
        assign unused_addr_bits = ^{bus.addra[ADDR_PORT_W-1:ADDR_W],
                                    bus.addrb[ADDR_PORT_W-1:ADDR_W]};
    end

    // One lane per byte; each lane sees only its own enable bit and data byte,
    // so arbitrary (even non-contiguous) enable patterns are honoured as given.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        data_ram_lane #(
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we_a   (bus.wea[i]),
            .addr_a (idx_a),
            .din_a  (lane_of(bus.dina, i)),
            .dout_a (rd_a[i]),
            .we_b   (bus.web[i]),
            .addr_b (idx_b),
            .din_b  (lane_of(bus.dinb, i)),
            .dout_b (rd_b[i])
        );
    end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed plus short random scoreboard bench for data_ram.
// Expected read data comes from a word-level reference memory in the bench.
// Honours DATA_RAM_WRITE_FIRST_EN when the RAM is built with it.
module tb_data_ram;
    import data_ram_pkg::*;

    localparam int ADDR_W = ADDR_W_DEFAULT;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;

    data_ram_if bus ();

    data_ram #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests_run;
    int tests_failed;

    word_t ref_mem [0:DEPTH-1];
    word_t exp_q_a [$];
    word_t exp_q_b [$];

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value.
    task automatic checkValue(input string tag, input word_t observed, input word_t expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Pop the scoreboard entries for this edge and compare both read ports.
    task automatic checkOutput(input string tag);
        word_t ea;
        word_t eb;
        if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL %s: scoreboard empty, observed %h expected an entry", tag, bus.douta);
        end else begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
            checkValue({tag, "_a"}, bus.douta, ea);
            checkValue({tag, "_b"}, bus.doutb, eb);
        end
    endtask

    // Drive one cycle of port traffic, predict both read results from the
    // reference memory, update the reference, then check after the edge.
    task automatic applyStimulus(input string tag,
                                 input lane_en_t a_we, input word_addr_t a_addr, input word_t a_din,
                                 input lane_en_t b_we, input word_addr_t b_addr, input word_t b_din);
        int    ia;
        int    ib;
        word_t exp_a;
        word_t exp_b;
        @(negedge clk);
        bus.wea   = a_we;
        bus.addra = a_addr;
        bus.dina  = a_din;
        bus.web   = b_we;
        bus.addrb = b_addr;
        bus.dinb  = b_din;
        ia = int'(a_addr % DEPTH);
        ib = int'(b_addr % DEPTH);
        exp_a = ref_mem[ia];
        exp_b = ref_mem[ib];
`ifdef DATA_RAM_WRITE_FIRST_EN
        for (int i = 0; i < LANES; i++) begin
            if (a_we[i]) exp_a[i*8 +: 8] = a_din[i*8 +: 8];
            if (b_we[i]) exp_b[i*8 +: 8] = b_din[i*8 +: 8];
        end
`endif
        exp_q_a.push_back(exp_a);
        exp_q_b.push_back(exp_b);
        for (int i = 0; i < LANES; i++) begin
            if (a_we[i]) ref_mem[ia][i*8 +: 8] = a_din[i*8 +: 8];
        end
        for (int i = 0; i < LANES; i++) begin
            if (b_we[i]) ref_mem[ib][i*8 +: 8] = b_din[i*8 +: 8];
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        rst       = 1'b1;
        bus.wea   = '0;
        bus.addra = '0;
        bus.dina  = '0;
        bus.web   = '0;
        bus.addrb = '0;
        bus.dinb  = '0;

        // Outputs held at zero while in reset.
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_douta", bus.douta, 32'h0);
        checkValue("reset_doutb", bus.doutb, 32'h0);

        @(negedge clk);
        rst = 1'b0;

        // Full-word write then readback on both ports.
        applyStimulus("wr_full", 4'b1111, 30'd5, 32'hDEADBEEF, 4'b0000, 30'd0, 32'h0);
        applyStimulus("rd_full", 4'b0000, 30'd5, 32'h0, 4'b0000, 30'd5, 32'h0);

        // Single-lane update keeps the other bytes.
        applyStimulus("wr_lane1", 4'b0010, 30'd5, 32'h0000AA00, 4'b0000, 30'd0, 32'h0);
        applyStimulus("rd_lane1", 4'b0000, 30'd5, 32'h0, 4'b0000, 30'd5, 32'h0);

        // Same-port read during write.
        applyStimulus("rdw_same", 4'b1111, 30'd7, 32'h11111111, 4'b0000, 30'd7, 32'h0);
        applyStimulus("rdw_after", 4'b0000, 30'd7, 32'h0, 4'b0000, 30'd7, 32'h0);

        // Both ports write word 3; port B owns the overlapping lanes.
        applyStimulus("collide", 4'b1111, 30'd3, 32'hAAAAAAAA, 4'b0011, 30'd3, 32'h55555555);
        applyStimulus("collide_rd", 4'b0000, 30'd3, 32'h0, 4'b0000, 30'd3, 32'h0);

        // Cross-port read of a word the other port is writing returns old data.
        applyStimulus("cross_a2b", 4'b1111, 30'd9, 32'hCAFEF00D, 4'b0000, 30'd9, 32'h0);
        applyStimulus("cross_b2a", 4'b0000, 30'd9, 32'h0, 4'b1111, 30'd9, 32'h0BADC0DE);
        applyStimulus("cross_rd", 4'b0000, 30'd9, 32'h0, 4'b0000, 30'd9, 32'h0);

        // Non-contiguous enables on both ports.
        applyStimulus("sparse_wr", 4'b1010, 30'd11, 32'h44332211, 4'b0101, 30'd12, 32'h88776655);
        applyStimulus("sparse_rd", 4'b0000, 30'd11, 32'h0, 4'b0000, 30'd12, 32'h0);

        // Address wrap modulo depth.
        applyStimulus("wrap_wr", 4'b1111, 30'd1, 32'h12345678, 4'b0000, 30'd0, 32'h0);
        applyStimulus("wrap_rd", 4'b0000, 30'(1 + DEPTH), 32'h0,
                      4'b0000, 30'(1 + 3 * DEPTH), 32'h0);

        // Put word 5 on both outputs, then reset mid-cycle with a write pending.
        applyStimulus("pre_rst", 4'b0000, 30'd5, 32'h0, 4'b0000, 30'd5, 32'h0);
        @(negedge clk);
        bus.wea   = 4'b1111;
        bus.addra = 30'd5;
        bus.dina  = 32'hFFFFFFFF;
        bus.web   = 4'b1111;
        bus.addrb = 30'd5;
        bus.dinb  = 32'hFFFFFFFF;
        #2;
        rst = 1'b1;
        #1;
        checkValue("async_rst_douta", bus.douta, 32'h0);
        checkValue("async_rst_doutb", bus.doutb, 32'h0);
        @(posedge clk);
        #1;
        checkValue("hold_rst_douta", bus.douta, 32'h0);
        checkValue("hold_rst_doutb", bus.doutb, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        bus.wea = 4'b0000;
        bus.web = 4'b0000;
        applyStimulus("post_rst", 4'b0000, 30'd5, 32'h0, 4'b0000, 30'd5, 32'h0);

        // Short random burst over a small address window.
        for (int n = 0; n < 24; n++) begin
            applyStimulus("random",
                          4'($urandom_range(0, 15)), 30'($urandom_range(0, 15)), $urandom(),
                          4'($urandom_range(0, 15)), 30'($urandom_range(0, 15)), $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
